// File: rtl/reg_file_sb.sv
// Multi-read register file with per-byte write enables, write-to-read bypass,
// an optional hardwired zero register and a per-register busy scoreboard.
module reg_file_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W/8-1:0]   wr_be,
   input  logic [ADDR_W-1:0]     rd_addr1,
   input  logic [ADDR_W-1:0]     rd_addr2,
   output logic [DATA_W-1:0]     rd_data1,
   output logic [DATA_W-1:0]     rd_data2,
   output logic                  rd_busy1,
   output logic                  rd_busy2,
   input  logic                  rsv_en,
   input  logic [ADDR_W-1:0]     rsv_addr,
   output logic                  rsv_ok,
   output logic [ADDR_W:0]       busy_cnt
);

   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int NBYTES = DATA_W / 8;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [ADDR_W:0]   busyCnt;
   logic              wrValid;
   logic              zeroRsv;
   logic              setValid;
   logic              clrValid;
   logic              cntInc;

   function automatic logic [DATA_W-1:0] mergeBytes(
      input logic [DATA_W-1:0] newVal,
      input logic [NBYTES-1:0] be,
      input logic [DATA_W-1:0] oldVal
   );
      logic [DATA_W-1:0] res;
      res = oldVal;
      for (int i = 0; i < NBYTES; i++) begin
         if (be[i]) res[8*i +: 8] = newVal[8*i +: 8];
      end
      return res;
   endfunction

   // A write in the same cycle as a reservation frees the slot, so the
   // reservation may be granted even though the register is still marked busy.
   assign wrValid  = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
   assign zeroRsv  = (ZERO_REG != 0) && (rsv_addr == '0);
   assign rsv_ok   = rsv_en && (zeroRsv || !busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));
   assign setValid = rsv_ok && !zeroRsv;
   assign clrValid = wr_en && busy[wr_addr] && !(setValid && (rsv_addr == wr_addr));
   assign cntInc   = setValid && !busy[rsv_addr];

   assign rd_busy1 = busy[rd_addr1];
   assign rd_busy2 = busy[rd_addr2];
   assign busy_cnt = busyCnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wrValid) begin
         regs[wr_addr] <= mergeBytes(wr_data, wr_be, regs[wr_addr]);
      end
   end

   // Set is applied after clear so a same-address reserve keeps the bit high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy    <= '0;
         busyCnt <= '0;
      end else begin
         if (clrValid) busy[wr_addr] <= 1'b0;
         if (setValid) busy[rsv_addr] <= 1'b1;
         case ({cntInc, clrValid})
            2'b10:   busyCnt <= busyCnt + 1'b1;
            2'b01:   busyCnt <= busyCnt - 1'b1;
            default: busyCnt <= busyCnt;
         endcase
      end
   end

   // The zero register override comes last so it beats the bypass path.
   always_comb begin
      rd_data1 = regs[rd_addr1];
      if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr1))
         rd_data1 = mergeBytes(wr_data, wr_be, regs[rd_addr1]);
      if ((ZERO_REG != 0) && (rd_addr1 == '0))
         rd_data1 = '0;
   end

   always_comb begin
      rd_data2 = regs[rd_addr2];
      if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr2))
         rd_data2 = mergeBytes(wr_data, wr_be, regs[rd_addr2]);
      if ((ZERO_REG != 0) && (rd_addr2 == '0))
         rd_data2 = '0;
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Testbench for reg_file_sb: three instances (default, no bypass, zero register)
// share one stimulus stream; expected values go through a scoreboard queue.
module tb_reg_file_sb;

   logic        clk;
   logic        reset;
   logic        wrEn;
   logic [3:0]  wrAddr;
   logic [31:0] wrData;
   logic [3:0]  wrBe;
   logic [3:0]  rdAddr1;
   logic [3:0]  rdAddr2;
   logic        rsvEn;
   logic [3:0]  rsvAddr;

   logic [31:0] aRd1, aRd2, nRd1, nRd2, zRd1, zRd2;
   logic        aB1, aB2, nB1, nB2, zB1, zB2;
   logic        aOk, nOk, zOk;
   logic [4:0]  aCnt, nCnt, zCnt;

   int total = 0;
   int bad   = 0;

   localparam int S_ARD1 = 0, S_ARD2 = 1, S_AB1 = 2, S_AB2 = 3, S_AOK = 4, S_ACNT = 5;
   localparam int S_NRD1 = 6, S_NRD2 = 7, S_ZRD1 = 8, S_ZOK = 9, S_ZB1 = 10, S_ZCNT = 11;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } expT;

   expT sb[$];

   typedef struct {
      logic        wrEn;
      logic [3:0]  wrAddr;
      logic [31:0] wrData;
      logic [3:0]  wrBe;
      logic [3:0]  rd1;
      logic [3:0]  rd2;
      logic        rsvEn;
      logic [3:0]  rsvAddr;
      logic [31:0] eRd1;
      logic [31:0] eRd2;
      logic        eB1;
      logic        eB2;
      logic        eOk;
      logic [4:0]  eCnt;
      logic        nbChk;
      logic [31:0] nRd1;
      logic [31:0] nRd2;
   } vecT;

   reg_file_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dut (
      .clk(clk), .reset(reset), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .wr_be(wrBe),
      .rd_addr1(rdAddr1), .rd_addr2(rdAddr2), .rd_data1(aRd1), .rd_data2(aRd2),
      .rd_busy1(aB1), .rd_busy2(aB2), .rsv_en(rsvEn), .rsv_addr(rsvAddr),
      .rsv_ok(aOk), .busy_cnt(aCnt)
   );

   reg_file_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) dutNb (
      .clk(clk), .reset(reset), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .wr_be(wrBe),
      .rd_addr1(rdAddr1), .rd_addr2(rdAddr2), .rd_data1(nRd1), .rd_data2(nRd2),
      .rd_busy1(nB1), .rd_busy2(nB2), .rsv_en(rsvEn), .rsv_addr(rsvAddr),
      .rsv_ok(nOk), .busy_cnt(nCnt)
   );

   reg_file_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dutZ (
      .clk(clk), .reset(reset), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData), .wr_be(wrBe),
      .rd_addr1(rdAddr1), .rd_addr2(rdAddr2), .rd_data1(zRd1), .rd_data2(zRd2),
      .rd_busy1(zB1), .rd_busy2(zB2), .rsv_en(rsvEn), .rsv_addr(rsvAddr),
      .rsv_ok(zOk), .busy_cnt(zCnt)
   );

   // 10-unit clock period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so a stuck run still reports and ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: act=timeout req=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] outSel(input int sel);
      case (sel)
         S_ARD1:  return aRd1;
         S_ARD2:  return aRd2;
         S_AB1:   return 32'(aB1);
         S_AB2:   return 32'(aB2);
         S_AOK:   return 32'(aOk);
         S_ACNT:  return 32'(aCnt);
         S_NRD1:  return nRd1;
         S_NRD2:  return nRd2;
         S_ZRD1:  return zRd1;
         S_ZOK:   return 32'(zOk);
         S_ZB1:   return 32'(zB1);
         S_ZCNT:  return 32'(zCnt);
         default: return 32'hXXXX_XXXX;
      endcase
   endfunction

   task automatic pushExp(input string name, input int sel, input logic [31:0] exp);
      expT e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      sb.push_back(e);
   endtask

   task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic [3:0] r1, input logic [3:0] r2,
                        input logic re, input logic [3:0] ra);
      wrEn = we; wrAddr = wa; wrData = wd; wrBe = be;
      rdAddr1 = r1; rdAddr2 = r2; rsvEn = re; rsvAddr = ra;
   endtask

   task automatic applyStimulus(input vecT v, input int idx);
      drive(v.wrEn, v.wrAddr, v.wrData, v.wrBe, v.rd1, v.rd2, v.rsvEn, v.rsvAddr);
      pushExp($sformatf("row%0d_rd1", idx), S_ARD1, v.eRd1);
      pushExp($sformatf("row%0d_rd2", idx), S_ARD2, v.eRd2);
      pushExp($sformatf("row%0d_busy1", idx), S_AB1, 32'(v.eB1));
      pushExp($sformatf("row%0d_busy2", idx), S_AB2, 32'(v.eB2));
      pushExp($sformatf("row%0d_rsvok", idx), S_AOK, 32'(v.eOk));
      pushExp($sformatf("row%0d_cnt", idx), S_ACNT, 32'(v.eCnt));
      if (v.nbChk) begin
         pushExp($sformatf("row%0d_nobyp_rd1", idx), S_NRD1, v.nRd1);
         pushExp($sformatf("row%0d_nobyp_rd2", idx), S_NRD2, v.nRd2);
      end
   endtask

   task automatic checkOutput();
      expT e;
      logic [31:0] act;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         act = outSel(e.sel);
         total++;
         if (act !== e.exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", e.name, act, e.exp);
         end
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   vecT vec[15];

   initial begin
      vec[0]  = '{1'b1, 4'd3, 32'h11223344, 4'hF, 4'd3, 4'd0, 1'b0, 4'd0,
                  32'h11223344, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0, 32'h0};
      vec[1]  = '{1'b1, 4'd3, 32'hAABBCCDD, 4'h5, 4'd3, 4'd3, 1'b0, 4'd0,
                  32'h11BB33DD, 32'h11BB33DD, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h11223344, 32'h11223344};
      vec[2]  = '{1'b0, 4'd0, 32'h0, 4'h0, 4'd3, 4'd4, 1'b0, 4'd0,
                  32'h11BB33DD, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h11BB33DD, 32'h0};
      vec[3]  = '{1'b1, 4'd4, 32'h5A5A5A5A, 4'hF, 4'd4, 4'd3, 1'b0, 4'd0,
                  32'h5A5A5A5A, 32'h11BB33DD, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0, 32'h11BB33DD};
      vec[4]  = '{1'b0, 4'd0, 32'h0, 4'h0, 4'd2, 4'd4, 1'b1, 4'd2,
                  32'h0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 32'h0, 32'h5A5A5A5A};
      vec[5]  = '{1'b0, 4'd0, 32'h0, 4'h0, 4'd2, 4'd4, 1'b1, 4'd2,
                  32'h0, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 32'h0, 32'h0};
      vec[6]  = '{1'b1, 4'd2, 32'h00000077, 4'hF, 4'd2, 4'd4, 1'b1, 4'd2,
                  32'h00000077, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 32'h0, 32'h0};
      vec[7]  = '{1'b0, 4'd0, 32'h0, 4'h0, 4'd2, 4'd4, 1'b0, 4'd0,
                  32'h00000077, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 32'h0, 32'h0};
      vec[8]  = '{1'b1, 4'd2, 32'hFFFFFFFF, 4'h0, 4'd2, 4'd4, 1'b0, 4'd0,
                  32'h00000077, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 32'h0, 32'h0};
      vec[9]  = '{1'b0, 4'd0, 32'h0, 4'h0, 4'd2, 4'd4, 1'b0, 4'd0,
                  32'h00000077, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0};
      vec[10] = '{1'b1, 4'd5, 32'hFFFFFFFF, 4'h0, 4'd5, 4'd6, 1'b1, 4'd6,
                  32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0, 32'h0};
      vec[11] = '{1'b1, 4'd6, 32'h12345678, 4'hC, 4'd7, 4'd6, 1'b1, 4'd7,
                  32'h0, 32'h12340000, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 32'h0, 32'h0};
      vec[12] = '{1'b0, 4'd0, 32'h0, 4'h0, 4'd7, 4'd6, 1'b0, 4'd0,
                  32'h0, 32'h12340000, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 32'h0, 32'h0};
      vec[13] = '{1'b1, 4'd7, 32'hCAFEF00D, 4'hF, 4'd7, 4'd6, 1'b0, 4'd0,
                  32'hCAFEF00D, 32'h12340000, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 32'h0, 32'h12340000};
      vec[14] = '{1'b0, 4'd0, 32'h0, 4'h0, 4'd7, 4'd6, 1'b0, 4'd0,
                  32'hCAFEF00D, 32'h12340000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'hCAFEF00D, 32'h12340000};

      reset = 1'b1;
      drive(1'b0, 4'd0, 32'h0, 4'h0, 4'd0, 4'd0, 1'b0, 4'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      pushExp("reset_rd1", S_ARD1, 32'h0);
      pushExp("reset_busy1", S_AB1, 32'h0);
      pushExp("reset_cnt", S_ACNT, 32'h0);
      checkOutput();

      // Table: byte enables, bypass, scoreboard reserve/release rules
      for (int i = 0; i < 15; i++) begin
         nextCycle();
         applyStimulus(vec[i], i);
         #2;
         checkOutput();
      end

      // Zero register: writes and reservations to r0 have no effect
      nextCycle();
      drive(1'b1, 4'd0, 32'hFFFFFFFF, 4'hF, 4'd0, 4'd0, 1'b1, 4'd0);
      pushExp("zero_rd1", S_ZRD1, 32'h0);
      pushExp("zero_rsvok", S_ZOK, 32'h1);
      pushExp("plain_r0_bypass", S_ARD1, 32'hFFFFFFFF);
      pushExp("plain_r0_rsvok", S_AOK, 32'h1);
      #2;
      checkOutput();
      nextCycle();
      drive(1'b0, 4'd0, 32'h0, 4'h0, 4'd0, 4'd0, 1'b0, 4'd0);
      pushExp("zero_rd1_after", S_ZRD1, 32'h0);
      pushExp("zero_busy_after", S_ZB1, 32'h0);
      pushExp("zero_cnt_after", S_ZCNT, 32'h0);
      pushExp("plain_r0_data", S_ARD1, 32'hFFFFFFFF);
      pushExp("plain_r0_busy", S_AB1, 32'h1);
      pushExp("plain_r0_cnt", S_ACNT, 32'h1);
      #2;
      checkOutput();

      // Fill: reserve every register, then release them all
      nextCycle();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         nextCycle();
         drive(1'b0, 4'd0, 32'h0, 4'h0, 4'd0, 4'd0, 1'b1, 4'(i));
         pushExp($sformatf("fill_rsvok_%0d", i), S_AOK, 32'h1);
         pushExp($sformatf("fill_cnt_%0d", i), S_ACNT, 32'(i));
         pushExp($sformatf("fill_zero_rsvok_%0d", i), S_ZOK, 32'h1);
         pushExp($sformatf("fill_zero_cnt_%0d", i), S_ZCNT, (i == 0) ? 32'h0 : 32'(i - 1));
         #2;
         checkOutput();
      end
      nextCycle();
      drive(1'b0, 4'd0, 32'h0, 4'h0, 4'd0, 4'd0, 1'b1, 4'd9);
      pushExp("full_retry_rsvok", S_AOK, 32'h0);
      pushExp("full_cnt", S_ACNT, 32'd16);
      pushExp("full_zero_cnt", S_ZCNT, 32'd15);
      #2;
      checkOutput();
      for (int i = 0; i < 16; i++) begin
         nextCycle();
         drive(1'b1, 4'(i), 32'h0, 4'h0, 4'd0, 4'd0, 1'b0, 4'd0);
         pushExp($sformatf("drain_cnt_%0d", i), S_ACNT, 32'(16 - i));
         pushExp($sformatf("drain_zero_cnt_%0d", i), S_ZCNT, (i == 0) ? 32'd15 : 32'(16 - i));
         #2;
         checkOutput();
      end
      nextCycle();
      drive(1'b0, 4'd0, 32'h0, 4'h0, 4'd0, 4'd0, 1'b0, 4'd0);
      pushExp("drained_cnt", S_ACNT, 32'h0);
      pushExp("drained_zero_cnt", S_ZCNT, 32'h0);
      #2;
      checkOutput();

      // Reset asserted between edges clears state immediately
      nextCycle();
      drive(1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 4'd0, 4'd0, 1'b0, 4'd0);
      nextCycle();
      drive(1'b0, 4'd0, 32'h0, 4'h0, 4'd0, 4'd0, 1'b1, 4'd7);
      nextCycle();
      drive(1'b0, 4'd0, 32'h0, 4'h0, 4'd5, 4'd7, 1'b0, 4'd0);
      #1;
      pushExp("pre_reset_rd1", S_ARD1, 32'hDEADBEEF);
      pushExp("pre_reset_busy2", S_AB2, 32'h1);
      pushExp("pre_reset_cnt", S_ACNT, 32'h1);
      checkOutput();
      #1;
      reset = 1'b1;
      #1;
      pushExp("mid_reset_rd1", S_ARD1, 32'h0);
      pushExp("mid_reset_busy2", S_AB2, 32'h0);
      pushExp("mid_reset_cnt", S_ACNT, 32'h0);
      checkOutput();
      nextCycle();
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
